// File: rtl/lsu_nb_mem_unit.sv
// Purpose : non-blocking load/store tracker between the LSU pipe and the dcache; tags every dcache request,
//           accepts responses out of order and completes them to the pipe strictly in issue order.
// Latency : request passes through combinationally; a response accepted at edge N is visible as resp_valid_o after edge N.
// Backpr. : req_ready_o follows dc_req_ready_i, and drops while the tracker is full or flush_i is high;
//           completions wait at head until resp_ready_i.
// Ports   : clk_i/rstn_i clock and async active-low reset; flush_i kills everything in flight;
//           req_* pipe request in; dc_req_* tagged request to dcache; dc_resp_* tagged dcache response;
//           resp_* in-order completion out; inflight_cnt_o current occupancy.
module lsu_nb_mem_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 7,
  parameter int unsigned ID_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       flush_i,
  // pipe request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [63:0]                req_addr_i,
  input  logic [63:0]                req_data_i,
  input  logic [3:0]                 req_size_i,
  input  logic                       req_is_store_i,
  input  logic [ID_W-1:0]            req_id_i,
  // dcache request
  output logic                       dc_req_valid_o,
  input  logic                       dc_req_ready_i,
  output logic [63:0]                dc_req_addr_o,
  output logic [63:0]                dc_req_data_o,
  output logic [3:0]                 dc_req_size_o,
  output logic                       dc_req_is_store_o,
  output logic [TAG_W-1:0]           dc_req_tag_o,
  // dcache response
  input  logic                       dc_resp_valid_i,
  input  logic [TAG_W-1:0]           dc_resp_tag_i,
  input  logic [63:0]                dc_resp_data_i,
  // in-order completion
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [ID_W-1:0]            resp_id_o,
  output logic [63:0]                resp_data_o,
  output logic                       resp_is_store_o,
  output logic [$clog2(DEPTH):0]     inflight_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // entry storage
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_done;
  logic [DEPTH-1:0] ent_killed;
  logic [DEPTH-1:0] ent_is_store;
  logic [TAG_W-1:0] ent_tag  [DEPTH];
  logic [ID_W-1:0]  ent_id   [DEPTH];
  logic [3:0]       ent_size [DEPTH];
  logic [2:0]       ent_addr [DEPTH];
  logic [63:0]      ent_data [DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] count_q;

  logic full;
  logic alloc;
  logic head_rdy;
  logic retire;

  assign full = (count_q == CNT_W'(DEPTH));

  // request path is a pure pass-through; only the handshake is gated
  assign dc_req_valid_o    = req_valid_i & ~full & ~flush_i;
  assign req_ready_o       = dc_req_ready_i & ~full & ~flush_i;
  assign dc_req_addr_o     = req_addr_i;
  assign dc_req_data_o     = req_data_i;
  assign dc_req_size_o     = req_size_i;
  assign dc_req_is_store_o = req_is_store_i;
  assign dc_req_tag_o      = tag_q;

  assign alloc = dc_req_valid_o & dc_req_ready_i;

  // head is complete once its response has landed; killed heads drop without a handshake
  assign head_rdy     = ent_valid[head_q] & ent_done[head_q];
  assign resp_valid_o = head_rdy & ~ent_killed[head_q];
  assign retire       = (head_rdy & ent_killed[head_q]) | (resp_valid_o & resp_ready_i);

  assign resp_id_o       = ent_id[head_q];
  assign resp_is_store_o = ent_is_store[head_q];
  assign inflight_cnt_o  = count_q;

  // load data formatting: the dcache returns the whole aligned dword, pick the lane by addr[2:0]
  logic [31:0] lane;
  logic [63:0] fmt_data;

  always_comb begin
    lane     = 32'(ent_data[head_q] >> {ent_addr[head_q], 3'b000});
    fmt_data = ent_data[head_q];
    case (ent_size[head_q])
      4'b0000: fmt_data = {{56{lane[7]}},  lane[7:0]};
      4'b0001: fmt_data = {{48{lane[15]}}, lane[15:0]};
      4'b0010: fmt_data = {{32{lane[31]}}, lane[31:0]};
      4'b0100: fmt_data = {56'd0, lane[7:0]};
      4'b0101: fmt_data = {48'd0, lane[15:0]};
      4'b0110: fmt_data = {32'd0, lane[31:0]};
      default: fmt_data = ent_data[head_q];
    endcase
    resp_data_o = ent_is_store[head_q] ? 64'd0 : fmt_data;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      tag_q        <= '0;
      count_q      <= '0;
      ent_valid    <= '0;
      ent_done     <= '0;
      ent_killed   <= '0;
      ent_is_store <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_tag[i]  <= '0;
        ent_id[i]   <= '0;
        ent_size[i] <= '0;
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      // tags in flight are unique (DEPTH < 2**TAG_W), so at most one entry matches
      if (dc_resp_valid_i) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (ent_valid[i] && !ent_done[i] && (ent_tag[i] == dc_resp_tag_i)) begin
            ent_done[i] <= 1'b1;
            ent_data[i] <= dc_resp_data_i;
          end
        end
      end

      // killed entries stay resident until their response drains
      if (flush_i) begin
        ent_killed <= ent_killed | ent_valid;
      end

      if (retire) begin
        ent_valid[head_q] <= 1'b0;
        head_q            <= head_q + PTR_W'(1);
      end

      // head and tail only coincide when empty or full, so retire and alloc never hit the same slot
      if (alloc) begin
        ent_valid[tail_q]    <= 1'b1;
        ent_done[tail_q]     <= 1'b0;
        ent_killed[tail_q]   <= 1'b0;
        ent_is_store[tail_q] <= req_is_store_i;
        ent_tag[tail_q]      <= tag_q;
        ent_id[tail_q]       <= req_id_i;
        ent_size[tail_q]     <= req_size_i;
        ent_addr[tail_q]     <= req_addr_i[2:0];
        tail_q               <= tail_q + PTR_W'(1);
        tag_q                <= tag_q + TAG_W'(1);
      end

      count_q <= count_q + CNT_W'(alloc) - CNT_W'(retire);
    end
  end

endmodule
